branch_target_buffer_sa: RTL
============================

# branch_target_buffer_sa

Set-associative branch target buffer with 2-bit saturating direction counters. It replaces the fully associative, combinationally updated branch history table in the fetch path. Fetch-stage lookup produces the next PC. The block holds its own registered IF→ID prediction and resolves it against the decode-stage branch outcome. All table updates, allocation and replacement occur on the clock edge, and mispredicts raise a redirect plus an IF/ID clear.

## Interface
- SETS, 32, number of sets; power of two, ≥2; IDX_W = log2(SETS)
- WAYS, 4, associativity; 1..8
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken)
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_f  in  32  fetch PC
- pcnext_f  out  32  predicted next fetch PC
- predtaken_f  out  1  lookup hit and counter[1]==1
- stalld  in  1  hold IF/ID; freezes prediction register, suppresses update and mispredict
- flushd  in  1  external clear of IF/ID; zeroes prediction register
- branchd  in  1  instruction in D is a resolved branch/jump
- takend  in  1  resolved direction
- pcd  in  32  PC of instruction in D
- pcbranchd  in  32  resolved target
- pcplus4d  in  32  pcd+4
- mispredictd  out  1  D-stage prediction wrong
- redirectpcd  out  32  correct next PC when mispredictd
- clrbp  out  1  clear IF/ID; equals mispredictd

## Operation
- Entry: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2]. pc[1:0] ignored.
- Lookup (combinational on pc_f): hit = any way valid with tag match; at most one way matches, and the lowest way wins if several do. predtaken_f = hit & ctr[1]. pcnext_f = predtaken_f ? target : pc_f+4.
- Prediction register (pred_valid, pred_taken, pred_target, pred_hit, pred_way):
  - When !stalld: loads the fetch lookup, or zero if flushd or mispredictd.
  - When stalld: holds, except that flushd zeroes it.
- Mispredict (combinational, gated by !stalld):
  - If branchd: (takend != pred_taken) | (takend & pcbranchd != pred_target).
  - If !branchd: pred_taken (alias hit on a non-branch).
  - redirectpcd = (branchd & takend) ? pcbranchd : pcplus4d.
  - mispredictd is 0 whenever stalld.
- Update (clock edge, !stalld, indexed by pcd):
  - branchd & pred_hit: ctr saturating +1 if takend, −1 if not (00↔11 clamp). If takend, write target ← pcbranchd.
  - branchd & !pred_hit & takend: allocate. The victim is the lowest invalid way, else the set's round-robin pointer, which then advances modulo WAYS. Write valid=1, tag, target, ctr=CTR_INIT.
  - branchd & !pred_hit & !takend: no write.
  - !branchd & pred_hit: invalidate pred_way.
- Round-robin pointer advances only on replacement of a valid way.

## Timing
- Lookup is zero latency: pcnext_f is valid in the same cycle as pc_f.
- A prediction made in cycle N is resolved in cycle N+1 (or later, while stalled).
- Update write at an edge is visible to a lookup in the following cycle. A same-cycle lookup to the updated set sees the old contents; there is no bypass.
- Reset state: all valid=0, pointers=0, prediction register=0.
- Reset outputs: predtaken_f=0, pcnext_f=pc_f+4, mispredictd=0, clrbp=0, redirectpcd=pcplus4d.
- Reset asserted mid-operation clears the table immediately. The first edge after deassertion performs a normal update.
- flushd and mispredictd in the same cycle: prediction register zeroed; the update still occurs if !stalld.

## Structure
- Shared package bp_pkg:
  - counter encodings: SNT=00, WNT=01, WT=10, ST=11
  - btb_entry_t struct
  - sat_inc / sat_dec functions
  - PC_W=32
- Sub-module btb_victim_sel: valid vector and pointer in, victim way out (lowest invalid, else pointer).
- Table storage is flip-flop arrays; no SRAM macro.

## Test plan
- Reset, pc_f=0x40 → predtaken_f=0, pcnext_f=0x44; branchd taken at pcd=0x40, pcbranchd=0x100 → mispredictd=1, redirectpcd=0x100, entry allocated with ctr=10.
- Refetch 0x40 → pcnext_f=0x100; resolve taken → no mispredict, ctr=11; two not-taken resolves → ctr 10 then 01, first resolve mispredicts with redirectpcd=0x44.
- WAYS+1 taken branches to the same set (stride SETS*4 from 0x40) → first WAYS fill ways 0..WAYS-1; the next replaces way 0 and the pointer becomes 1.
- Hit at 0x40 with target 0x100, resolved taken to 0x200 → mispredictd=1, redirectpcd=0x200, stored target updated to 0x200.
- stalld=1 for 3 cycles with a taken mismatch in D → mispredictd=0 and no update until stalld falls, then a single update; flushd during the stall zeroes the prediction register.
- Non-branch at a hit PC (alias) → mispredictd=1, redirectpcd=pcplus4d, entry invalidated.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target buffer: counter encoding,
// table entry layout and saturating counter arithmetic.
package bp_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tag is held at full PC width; the bits above the real tag are always zero.
  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] tag;
    logic [PC_W-1:0] target;
    ctr_t            ctr;
  } btb_entry_t;

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Replacement victim for one set: lowest invalid way, else the round-robin pointer.
module btb_victim_sel #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-1:0]                              valid_i,
  input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]   ptr_i,
  output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]   victim_c,
  output logic                                         all_valid_c
);

  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  // Scan high to low so the lowest invalid way is the one left standing.
  always_comb begin
    victim_c    = ptr_i;
    all_valid_c = &valid_i;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_i[w]) victim_c = WAY_W'(w);
    end
  end

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative BTB with 2-bit direction counters: zero-latency fetch lookup,
// registered IF->ID prediction, and decode-stage resolution/update.
module branch_target_buffer_sa
  import bp_pkg::*;
#(
  parameter int unsigned SETS     = 32,
  parameter int unsigned WAYS     = 4,
  parameter logic [1:0]  CTR_INIT = 2'b10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_f,
  output logic [PC_W-1:0] pcnext_f,
  output logic            predtaken_f,
  input  logic            stalld,
  input  logic            flushd,
  input  logic            branchd,
  input  logic            takend,
  input  logic [PC_W-1:0] pcd,
  input  logic [PC_W-1:0] pcbranchd,
  input  logic [PC_W-1:0] pcplus4d,
  output logic            mispredictd,
  output logic [PC_W-1:0] redirectpcd,
  output logic            clrbp
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_entry_t       table_q [SETS][WAYS];
  btb_entry_t       table_d [SETS][WAYS];
  logic [WAY_W-1:0] ptr_q   [SETS];
  logic [WAY_W-1:0] ptr_d   [SETS];

  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic [PC_W-1:0]  pred_target_q, pred_target_d;
  logic             pred_hit_q, pred_hit_d;
  logic [WAY_W-1:0] pred_way_q, pred_way_d;

  logic [IDX_W-1:0] idx_f, idx_d;
  logic [PC_W-1:0]  tag_f, tag_d;
  logic             hit_c;
  logic [WAY_W-1:0] hit_way_c;
  logic             pred_taken_c, pred_hit_c;
  logic [WAYS-1:0]  set_valid_c;
  logic [WAY_W-1:0] victim_c;
  logic             all_valid_c;
  logic             unused_pc_lsbs;

  assign idx_f = pc_f[IDX_W+1:2];
  assign tag_f = PC_W'(pc_f[PC_W-1:IDX_W+2]);
  assign idx_d = pcd[IDX_W+1:2];
  assign tag_d = PC_W'(pcd[PC_W-1:IDX_W+2]);
  assign unused_pc_lsbs = ^{pc_f[1:0], pcd[1:0]};

  // Fetch lookup; descending scan leaves the lowest matching way.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (table_q[idx_f][w].valid && (table_q[idx_f][w].tag == tag_f)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  assign predtaken_f = hit_c & table_q[idx_f][hit_way_c].ctr[1];
  assign pcnext_f    = predtaken_f ? table_q[idx_f][hit_way_c].target : pc_f + PC_W'(4);

  assign pred_taken_c = pred_valid_q & pred_taken_q;
  assign pred_hit_c   = pred_valid_q & pred_hit_q;

  // Resolution against the held prediction; a stalled D stage never redirects.
  always_comb begin
    mispredictd = 1'b0;
    if (!stalld) begin
      if (branchd) begin
        mispredictd = (takend != pred_taken_c) | (takend & (pcbranchd != pred_target_q));
      end else begin
        mispredictd = pred_taken_c;
      end
    end
  end

  assign redirectpcd = (branchd & takend) ? pcbranchd : pcplus4d;
  assign clrbp       = mispredictd;

  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) set_valid_c[w] = table_q[idx_d][w].valid;
  end

  btb_victim_sel #(.WAYS(WAYS)) u_victim_sel (
    .valid_i     (set_valid_c),
    .ptr_i       (ptr_q[idx_d]),
    .victim_c    (victim_c),
    .all_valid_c (all_valid_c)
  );

  // Table update from the D stage: train on hit, allocate on taken miss, drop aliases.
  always_comb begin
    table_d = table_q;
    ptr_d   = ptr_q;
    if (!stalld) begin
      if (branchd && pred_hit_c) begin
        table_d[idx_d][pred_way_q].ctr = takend ? sat_inc(table_q[idx_d][pred_way_q].ctr)
                                                : sat_dec(table_q[idx_d][pred_way_q].ctr);
        if (takend) table_d[idx_d][pred_way_q].target = pcbranchd;
      end else if (branchd && takend) begin
        table_d[idx_d][victim_c] = '{valid: 1'b1, tag: tag_d, target: pcbranchd,
                                     ctr: ctr_t'(CTR_INIT)};
        if (all_valid_c) begin
          ptr_d[idx_d] = (ptr_q[idx_d] == WAY_W'(WAYS - 1)) ? '0
                                                            : WAY_W'(ptr_q[idx_d] + WAY_W'(1));
        end
      end else if (!branchd && pred_hit_c) begin
        table_d[idx_d][pred_way_q].valid = 1'b0;
      end
    end
  end

  always_comb begin
    pred_valid_d  = pred_valid_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    pred_hit_d    = pred_hit_q;
    pred_way_d    = pred_way_q;
    if ((!stalld && (flushd || mispredictd)) || (stalld && flushd)) begin
      pred_valid_d  = 1'b0;
      pred_taken_d  = 1'b0;
      pred_target_d = '0;
      pred_hit_d    = 1'b0;
      pred_way_d    = '0;
    end else if (!stalld) begin
      pred_valid_d  = 1'b1;
      pred_taken_d  = predtaken_f;
      pred_target_d = pcnext_f;
      pred_hit_d    = hit_c;
      pred_way_d    = hit_way_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        ptr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) table_q[s][w] <= '0;
      end
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_hit_q    <= 1'b0;
      pred_way_q    <= '0;
    end else begin
      table_q       <= table_d;
      ptr_q         <= ptr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      pred_hit_q    <= pred_hit_d;
      pred_way_q    <= pred_way_d;
    end
  end

endmodule
